// File: rtl/spi_master_cfg.sv
// SPI master with per-transfer CPOL/CPHA, chip-select index and a fixed sclk divider.
// Define SPI_LOOPBACK_EN to feed the internal mosi back into the receive shifter instead of miso.
module spi_master_cfg #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 2,
  parameter int CLK_DIV = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              cpha_q;
  logic [CS_W-1:0]   cs_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              mosi_en;
  logic              accept;
  logic              div_tick;
  logic              lead_edge;
  logic              last_edge;
  logic              sample_now;
  logic              rx_bit;

  assign accept     = (state == IDLE) && start && ({1'b0, cs_sel} < (CS_W + 1)'(NUM_CS));
  assign div_tick   = (div_cnt == DIV_LAST);
  // Edges are numbered from 0: even indices are leading edges, odd are trailing.
  assign lead_edge  = ~edge_cnt[0];
  assign last_edge  = (edge_cnt == EDGE_LAST);
  assign sample_now = cpha_q ? ~lead_edge : lead_edge;

  assign mosi = mosi_en & tx_sr[DATA_W-1];
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign cs_n = (state == SETUP || state == XFER || state == HOLD) ?
                ~(NUM_CS'(1) << cs_q) : '1;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      cs_q     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      mosi_en  <= 1'b0;
      sclk     <= 1'b0;
      dout     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SETUP;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpha_q   <= cpha;
            cs_q     <= cs_sel;
            sclk     <= cpol;
            tx_sr    <= din;
            rx_sr    <= '0;
            // With cpha=0 the MSB must already be on mosi before the first leading edge.
            mosi_en  <= ~cpha;
          end
        end
        SETUP: begin
          if (div_tick) begin
            state   <= XFER;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        XFER: begin
          if (div_tick) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (sample_now) begin
              rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
            end
            if (cpha_q) begin
              if (lead_edge) begin
                if (edge_cnt == '0) begin
                  mosi_en <= 1'b1;
                end else begin
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end
              end
            end else if (!lead_edge && !last_edge) begin
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (last_edge) begin
              state <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_tick) begin
            state   <= DONE;
            div_cnt <= '0;
            dout    <= rx_sr;
            mosi_en <= 1'b0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Randomized scoreboard bench for spi_master_cfg with a mode-matched SPI slave model.
// With SPI_LOOPBACK_EN defined it runs a 16-bit, divide-by-1 build and expects dout == din.
module tb_spi_master_cfg;
`ifdef SPI_LOOPBACK_EN
  localparam int DW = 16;
  localparam int CD = 1;
  localparam logic [DW-1:0] DIR_DIN = 16'hBEEF;
`else
  localparam int DW = 8;
  localparam int CD = 2;
  localparam logic [DW-1:0] DIR_DIN = 8'hA5;
`endif
  localparam int NCS = 3;
  localparam int CSW = 2;
  localparam int LAT = (2 * DW + 2) * CD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic miso = 1'b0;
  logic [DW-1:0] din = '0;
  logic [CSW-1:0] cs_sel = '0;
  logic sclk, mosi, busy, done;
  logic [NCS-1:0] cs_n;
  logic [DW-1:0] dout;

  spi_master_cfg #(.DATA_W(DW), .NUM_CS(NCS), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
    int            cs;
    logic          cpol;
    int            acc;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  // Slave model state, loaded by the driver before each start
  logic [DW-1:0] sl_word = '0;
  logic sl_cpol = 1'b0;
  logic sl_cpha = 1'b0;
  logic [DW-1:0] sl_rx = '0;
  int sl_idx = 0;
  int sl_edges = 0;
  int bsy_cnt = 0;
  logic prev_sclk = 1'b0, prev_act = 1'b0, prev_done = 1'b0;
  logic cs_bad = 1'b0, idle_bad = 1'b0, multi_bad = 1'b0, sclk_first = 1'b0;
  logic [NCS-1:0] cs_seen = '1;

  always @(negedge clk) begin
    logic act;
    logic [NCS-1:0] want_cs;
    exp_t e;
    act = ~&cs_n;
    if (!rst) q.delete();
    if (!busy && mosi !== 1'b0) idle_bad = 1'b1;
    if ($countones(~cs_n) > 1) multi_bad = 1'b1;
    if (act && !prev_act) begin
      sl_edges = 0; sl_rx = '0; sl_idx = DW - 1; cs_seen = cs_n;
      sclk_first = sclk; cs_bad = 1'b0; bsy_cnt = 0;
      if (!sl_cpha) miso = sl_word[DW-1];
    end else if (act) begin
      if (cs_n !== cs_seen) cs_bad = 1'b1;
      if (sclk !== prev_sclk) begin
        sl_edges++;
        if (sclk !== sl_cpol) begin
          if (sl_cpha) begin
            if (sl_idx >= 0) miso = sl_word[sl_idx];
            sl_idx--;
          end else begin
            sl_rx = {sl_rx[DW-2:0], mosi};
          end
        end else begin
          if (sl_cpha) begin
            sl_rx = {sl_rx[DW-2:0], mosi};
          end else begin
            sl_idx--;
            if (sl_idx >= 0) miso = sl_word[sl_idx];
          end
        end
      end
    end
    if (busy) bsy_cnt++;
    if (done) begin
      check("done_width", prev_done, 1'b0);
      check("queue_has_entry", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        want_cs = ~(NCS'(1) << e.cs);
        check("dout", dout, e.exp);
        check("mosi_word", sl_rx, e.din);
        check("sclk_edges", sl_edges, 2 * DW);
        check("done_latency", cyc - e.acc, LAT);
        check("busy_cycles", bsy_cnt, LAT + 1);
        check("cs_n_active", cs_seen, want_cs);
        check("cs_n_stable", cs_bad, 1'b0);
        check("sclk_idle_start", sclk_first, e.cpol);
        check("sclk_idle_end", sclk, e.cpol);
        check("cs_n_release", cs_n, {NCS{1'b1}});
      end
    end
    prev_done = done;
    prev_sclk = sclk;
    prev_act  = act;
  end

  int next_free = 0;
  int last_acc = -100;

  task automatic junk();
    start  = 1'($urandom_range(0, 1));
    din    = DW'($urandom);
    cs_sel = CSW'($urandom);
    cpol   = 1'($urandom);
    cpha   = 1'($urandom);
    if (cyc + 1 == last_acc + 10) begin
      start = 1'b1;
      din   = '1;
    end
  endtask

  task automatic xfer(input logic [DW-1:0] d, input int cs, input logic p, input logic h,
                      input logic [DW-1:0] sw, input int off);
    int target;
    exp_t e;
    target = next_free + off;
    while (cyc + 1 < target) begin
      if (cyc + 1 < next_free) begin
        junk();
      end else begin
        start  = 1'($urandom_range(0, 1));
        cs_sel = CSW'(NCS);
        din    = DW'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b1; din = d; cs_sel = CSW'(cs); cpol = p; cpha = h;
    sl_word = sw; sl_cpol = p; sl_cpha = h;
    do @(negedge clk); while (cyc < next_free);
    start = 1'b0;
    e.din = d;
`ifdef SPI_LOOPBACK_EN
    e.exp = d;
`else
    e.exp = sw;
`endif
    e.cs = cs; e.cpol = p; e.acc = cyc;
    q.push_back(e);
    last_acc  = cyc;
    next_free = cyc + LAT + 2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, pending %0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_cs_n", cs_n, {NCS{1'b1}});
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, '0);
    repeat (2) @(negedge clk);
    next_free = cyc + 1;
    #2 rst = 1'b1;

    // Out-of-range select must be ignored
    @(negedge clk);
    start = 1'b1; cs_sel = CSW'(NCS); din = DIR_DIN;
    repeat (4) begin
      @(negedge clk);
      check("bad_sel_busy", busy, 1'b0);
      check("bad_sel_cs_n", cs_n, {NCS{1'b1}});
    end
    start = 1'b0;
    next_free = cyc + 1;

    xfer(DIR_DIN, 1, 1'b0, 1'b0, DW'(8'h3C), 0);
    for (int m = 0; m < 4; m++)
      xfer(DW'(8'h81), $urandom_range(0, NCS - 1), m[1], m[0], DW'($urandom), 0);
    repeat (16)
      xfer(DW'($urandom), $urandom_range(0, NCS - 1), 1'($urandom), 1'($urandom),
           DW'($urandom), $urandom_range(0, 4) - 1);

    // Abort mid-transfer with an asynchronous reset
    xfer(DW'($urandom), 2, 1'b1, 1'b0, DW'($urandom), 0);
    while (cyc < last_acc + 12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_cs_n", cs_n, {NCS{1'b1}});
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    check("abort_dout", dout, '0);
    repeat (3) @(negedge clk);
    check("abort_dout_held", dout, '0);
    next_free = cyc + 1;
    #2 rst = 1'b1;

    repeat (3)
      xfer(DW'($urandom), $urandom_range(0, NCS - 1), 1'($urandom), 1'($urandom),
           DW'($urandom), $urandom_range(0, 4) - 1);
    while (cyc < next_free + 3) begin
      start = 1'b0;
      @(negedge clk);
    end
    check("pending_transfers", q.size(), 0);
    check("mosi_idle_zero", idle_bad, 1'b0);
    check("cs_n_onehot", multi_bad, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
